// File: rtl/track_scan_sequencer.sv
// Track index sequencer: steps through NUM_TRACKS slots with a programmable dwell,
// optionally skipping tracks whose bit in track_vec is clear.
module track_scan_sequencer #(
  parameter int NUM_TRACKS = 16,
  parameter int IDX_W      = 4,
  parameter int DWELL      = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  mode,
  input  logic [NUM_TRACKS-1:0] track_vec,
  output logic [IDX_W-1:0]      track_iter,
  output logic                  iter_valid,
  output logic                  wrap
);

  localparam int                CNT_W      = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0]  DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_TRACKS - 1);

  localparam logic MODE_SEQ  = 1'b0;
  localparam logic MODE_SKIP = 1'b1;

  generate
    if (NUM_TRACKS < 2 || (2 ** IDX_W) < NUM_TRACKS || DWELL < 1) begin : g_bad_params
      $error("track_scan_sequencer: illegal NUM_TRACKS/IDX_W/DWELL combination");
    end
  endgenerate

  logic [CNT_W-1:0] dwell_cnt;
  logic             started;
  logic             advance;

  logic             any_set;
  logic [IDX_W-1:0] first_idx;
  logic             next_found;
  logic [IDX_W-1:0] next_idx;

  assign advance = en && (dwell_cnt == DWELL_LAST);

  // Single-pass priority search: scanning from the top down lets the lowest
  // qualifying index overwrite earlier hits, for both the overall and the
  // "strictly above current" candidate.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    any_set    = |track_vec;
    first_idx  = '0;
    next_found = 1'b0;
    next_idx   = '0;
    for (int i = NUM_TRACKS - 1; i >= 0; i--) begin
      if (track_vec[i]) begin
        first_idx = IDX_W'(i);
        if (IDX_W'(i) > track_iter) begin
          next_found = 1'b1;
          next_idx   = IDX_W'(i);
        end
      end
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      track_iter <= '0;
      iter_valid <= 1'b0;
      wrap       <= 1'b0;
      dwell_cnt  <= '0;
      started    <= 1'b0;
    end else begin
      wrap <= 1'b0;

      if (en) begin
        dwell_cnt <= advance ? '0 : dwell_cnt + CNT_W'(1);
      end

      if (advance) begin
        started <= 1'b1;
        if (!started) begin
          // First advance of a pass never reports a wrap.
          if (mode == MODE_SEQ) begin
            track_iter <= '0;
            iter_valid <= 1'b1;
          end else if (any_set) begin
            track_iter <= first_idx;
            iter_valid <= 1'b1;
          end else begin
            iter_valid <= 1'b0;
          end
        end else if (mode == MODE_SEQ) begin
          iter_valid <= 1'b1;
          if (track_iter == LAST_IDX) begin
            track_iter <= '0;
            wrap       <= 1'b1;
          end else begin
            track_iter <= track_iter + IDX_W'(1);
          end
        end else if (mode == MODE_SKIP) begin
          if (!any_set) begin
            iter_valid <= 1'b0;
          end else if (next_found) begin
            track_iter <= next_idx;
            iter_valid <= 1'b1;
          end else begin
            track_iter <= first_idx;
            iter_valid <= 1'b1;
            wrap       <= 1'b1;
          end
        end
      end
    end
  end

endmodule
